// File: rtl/hazard_scoreboard_pkg.sv
// Shared forward-select codes and the nearest-stage pick used by every forward mux.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_ORIG = 2'b00,
    FWD_E    = 2'b01,
    FWD_M    = 2'b10,
    FWD_W    = 2'b11
  } fwd_e;

  // hit/rdy bit 0 = E, 1 = M, 2 = W; a nearer hit that is not ready shadows farther ones.
  function automatic fwd_e fwd_pick(input logic [2:0] hit, input logic [2:0] rdy);
    if (hit[0])      return rdy[0] ? FWD_E : FWD_ORIG;
    else if (hit[1]) return rdy[1] ? FWD_M : FWD_ORIG;
    else if (hit[2]) return rdy[2] ? FWD_W : FWD_ORIG;
    return FWD_ORIG;
  endfunction

endpackage

// File: rtl/hazard_track_stage.sv
// One tracking entry: payload plus tnew, loads a bubble on request and optionally
// decrements tnew (saturating at zero) as the entry advances.
module hazard_track_stage #(
  parameter int PW     = 8,
  parameter int TNEW_W = 2,
  parameter bit DEC    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic [PW-1:0]     pay_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [PW-1:0]     pay_o,
  output logic [TNEW_W-1:0] tnew_o
);

  logic [PW-1:0]     pay_d, pay_q;
  logic [TNEW_W-1:0] tnew_d, tnew_q;

  always_comb begin
    pay_d  = pay_i;
    tnew_d = tnew_i;
    if (DEC && tnew_i != '0) tnew_d = tnew_i - TNEW_W'(1);
    if (bubble) begin
      pay_d  = '0;
      tnew_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pay_q  <= '0;
      tnew_q <= '0;
    end else begin
      pay_q  <= pay_d;
      tnew_q <= tnew_d;
    end
  end

  assign pay_o  = pay_q;
  assign tnew_o = tnew_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for the 5-stage pipeline: tracks E/M/W destinations and
// Tnew internally, drives stall and all forward selects, and owns the MD busy counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [TNEW_W-1:0] D_tuse_rs,
  input  logic [TNEW_W-1:0] D_tuse_rt,
  input  logic [REG_AW-1:0] D_wreg,
  input  logic              D_we,
  input  logic [TNEW_W-1:0] D_tnew,
  input  logic              D_md_start,
  input  logic              D_md_is_div,
  input  logic              D_md_use,
  output logic              stall,
  output logic              md_busy,
  output logic [1:0]        s_D_rs,
  output logic [1:0]        s_D_rt,
  output logic [1:0]        s_E_rs,
  output logic [1:0]        s_E_rt,
  output logic [1:0]        s_M_rt
);

  // Each stage keeps only the fields something downstream still looks at.
  localparam int EPW = 3*REG_AW + 3;
  localparam int MPW = 2*REG_AW + 1;
  localparam int WPW = REG_AW + 1;

  logic [EPW-1:0]    e_pay;
  logic [MPW-1:0]    m_pay;
  logic [WPW-1:0]    w_pay;
  logic [TNEW_W-1:0] e_tnew, m_tnew, w_tnew;
  logic              e_mds, e_mdd, e_we, m_we, w_we;
  logic [REG_AW-1:0] e_rs, e_rt, e_wreg, m_rt, m_wreg, w_wreg;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  hazard_track_stage #(.PW(EPW), .TNEW_W(TNEW_W), .DEC(1'b0)) u_e (
    .clk(clk), .reset(reset), .bubble(stall),
    .pay_i({D_md_start, D_md_is_div, D_rs, D_rt, D_wreg, D_we}),
    .tnew_i(D_tnew), .pay_o(e_pay), .tnew_o(e_tnew)
  );

  hazard_track_stage #(.PW(MPW), .TNEW_W(TNEW_W), .DEC(1'b1)) u_m (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .pay_i({e_rt, e_wreg, e_we}),
    .tnew_i(e_tnew), .pay_o(m_pay), .tnew_o(m_tnew)
  );

  hazard_track_stage #(.PW(WPW), .TNEW_W(TNEW_W), .DEC(1'b1)) u_w (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .pay_i({m_wreg, m_we}),
    .tnew_i(m_tnew), .pay_o(w_pay), .tnew_o(w_tnew)
  );

  assign {e_mds, e_mdd, e_rs, e_rt, e_wreg, e_we} = e_pay;
  assign {m_rt, m_wreg, m_we}                     = m_pay;
  assign {w_wreg, w_we}                           = w_pay;

  function automatic logic hit(input logic we, input logic [REG_AW-1:0] wreg,
                               input logic [REG_AW-1:0] r);
    return we && (wreg == r) && (r != '0);
  endfunction

  function automatic logic late(input logic [2:0] h, input logic [TNEW_W-1:0] tuse,
                                input logic [TNEW_W-1:0] te, input logic [TNEW_W-1:0] tm,
                                input logic [TNEW_W-1:0] tw);
    if (h[0])      return te > tuse;
    else if (h[1]) return tm > tuse;
    else if (h[2]) return tw > tuse;
    return 1'b0;
  endfunction

  logic [2:0] h_rs, h_rt, rdy;

  always_comb begin
    h_rs    = {hit(w_we, w_wreg, D_rs), hit(m_we, m_wreg, D_rs), hit(e_we, e_wreg, D_rs)};
    h_rt    = {hit(w_we, w_wreg, D_rt), hit(m_we, m_wreg, D_rt), hit(e_we, e_wreg, D_rt)};
    rdy     = {w_tnew == '0, m_tnew == '0, e_tnew == '0};
    s_D_rs  = fwd_pick(h_rs, rdy);
    s_D_rt  = fwd_pick(h_rt, rdy);
    s_E_rs  = fwd_pick({hit(w_we, w_wreg, e_rs), hit(m_we, m_wreg, e_rs), 1'b0}, rdy);
    s_E_rt  = fwd_pick({hit(w_we, w_wreg, e_rt), hit(m_we, m_wreg, e_rt), 1'b0}, rdy);
    s_M_rt  = fwd_pick({hit(w_we, w_wreg, m_rt), 2'b00}, rdy);
    md_busy = e_mds || (cnt_q != '0);
    stall   = late(h_rs, D_tuse_rs, e_tnew, m_tnew, w_tnew)
            | late(h_rt, D_tuse_rt, e_tnew, m_tnew, w_tnew)
            | (D_md_use && md_busy);
  end

  // The counter is loaded only when the MD op actually sits in E, so a stalled start never counts.
  always_comb begin
    cnt_d = cnt_q;
    if (e_mds)              cnt_d = e_mdd ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an instruction-level model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_wreg;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_we, D_md_start, D_md_is_div, D_md_use;
  logic       stall, md_busy;
  logic [1:0] s_D_rs, s_D_rt, s_E_rs, s_E_rt, s_M_rt;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_wreg(D_wreg), .D_we(D_we), .D_tnew(D_tnew),
    .D_md_start(D_md_start), .D_md_is_div(D_md_is_div), .D_md_use(D_md_use),
    .stall(stall), .md_busy(md_busy),
    .s_D_rs(s_D_rs), .s_D_rt(s_D_rt), .s_E_rs(s_E_rs), .s_E_rt(s_E_rt), .s_M_rt(s_M_rt)
  );

  // Model: the three in-flight instructions, index 0 = E, 1 = M, 2 = W.
  typedef struct {
    int wreg; bit we; int tnew; int rs; int rt; bit mds; bit mdd;
  } ins_t;

  ins_t pipe[3];
  int   md_left;
  bit   last_stall;
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic ins_t nop_ins();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  // Nearest writer of r at or beyond stage 'from', or -1.
  function automatic int writer(int r, int from);
    for (int s = from; s < 3; s++)
      if (r != 0 && pipe[s].we && pipe[s].wreg == r) return s;
    return -1;
  endfunction

  function automatic int fwd_code(int r, int from);
    int s;
    s = writer(r, from);
    if (s < 0) return 0;
    return (pipe[s].tnew == 0) ? s + 1 : 0;
  endfunction

  function automatic bit must_wait(int r, int tuse);
    int s;
    s = writer(r, 0);
    return (s >= 0) && (pipe[s].tnew > tuse);
  endfunction

  function automatic bit exp_busy();
    return pipe[0].mds || md_left != 0;
  endfunction

  function automatic bit exp_stall();
    return must_wait(int'(D_rs), int'(D_tuse_rs)) || must_wait(int'(D_rt), int'(D_tuse_rt))
        || (D_md_use && exp_busy());
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic check_all();
    chk("stall",   int'(stall),   int'(exp_stall()));
    chk("md_busy", int'(md_busy), int'(exp_busy()));
    chk("s_D_rs",  int'(s_D_rs),  fwd_code(int'(D_rs), 0));
    chk("s_D_rt",  int'(s_D_rt),  fwd_code(int'(D_rt), 0));
    chk("s_E_rs",  int'(s_E_rs),  fwd_code(pipe[0].rs, 1));
    chk("s_E_rt",  int'(s_E_rt),  fwd_code(pipe[0].rt, 1));
    chk("s_M_rt",  int'(s_M_rt),  fwd_code(pipe[1].rt, 2));
  endtask

  task automatic model_update();
    ins_t d;
    if (reset) begin
      for (int s = 0; s < 3; s++) pipe[s] = nop_ins();
      md_left    = 0;
      last_stall = 1'b0;
      return;
    end
    last_stall = exp_stall();
    if (pipe[0].mds)      md_left = pipe[0].mdd ? 10 : 5;
    else if (md_left > 0) md_left--;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    for (int s = 1; s < 3; s++) if (pipe[s].tnew > 0) pipe[s].tnew--;
    d = '{wreg: int'(D_wreg), we: D_we, tnew: int'(D_tnew), rs: int'(D_rs), rt: int'(D_rt),
          mds: D_md_start, mdd: D_md_is_div};
    pipe[0] = last_stall ? nop_ins() : d;
  endtask

  task automatic set_d(int rs, int tu_rs, int rt, int tu_rt, int wreg, int we, int tnew,
                       int mds, int mdd, int mdu);
    D_rs = 5'(rs); D_tuse_rs = 2'(tu_rs); D_rt = 5'(rt); D_tuse_rt = 2'(tu_rt);
    D_wreg = 5'(wreg); D_we = 1'(we); D_tnew = 2'(tnew);
    D_md_start = 1'(mds); D_md_is_div = 1'(mdd); D_md_use = 1'(mdu);
  endtask

  task automatic nop();
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_d();
    int mds;
    mds = ($urandom_range(7) == 0) ? 1 : 0;
    set_d($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
          $urandom_range(3), $urandom_range(1), $urandom_range(3),
          mds, $urandom_range(1), (mds != 0 || $urandom_range(5) == 0) ? 1 : 0);
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  int cnt;

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = nop_ins();
    md_left = 0;
    last_stall = 1'b0;

    // Reset with hostile D inputs: outputs must still be quiet afterwards.
    reset = 1'b1;
    set_d(3, 0, 2, 0, 3, 1, 3, 1, 1, 1);
    adv();
    reset = 1'b0;
    sample();
    chk("rst_stall", int'(stall), 0);
    chk("rst_busy",  int'(md_busy), 0);
    chk("rst_sDrs",  int'(s_D_rs), 0);
    adv();
    nop(); sample(); adv(); sample(); adv(); sample(); adv();

    // Load-use: lw $5 tnew=2 then beq rs=$5 tuse=0.
    set_d(0, 3, 0, 3, 5, 1, 2, 0, 0, 0);
    sample(); adv();
    set_d(5, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    sample(); chk("lw_stall1", int'(stall), 1); adv();
    sample(); chk("lw_stall2", int'(stall), 1); adv();
    sample(); chk("lw_release", int'(stall), 0); chk("lw_fwd_W", int'(s_D_rs), 3); adv();

    // addu $3 tnew=1 followed by consumer tuse=1: no stall, then forward from M in E.
    set_d(0, 3, 0, 3, 3, 1, 1, 0, 0, 0);
    sample(); adv();
    set_d(3, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    sample(); chk("addu_stall", int'(stall), 0); chk("addu_sDrs", int'(s_D_rs), 0); adv();
    nop();
    sample(); chk("addu_sErs", int'(s_E_rs), 2); adv();

    // lw $5 then ori $5: the ori must shadow the stale lw.
    set_d(0, 3, 0, 3, 5, 1, 2, 0, 0, 0);
    sample(); adv();
    set_d(0, 3, 0, 3, 5, 1, 1, 0, 0, 0);
    sample(); adv();
    set_d(5, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    sample(); chk("shadow_sDrs", int'(s_D_rs), 0); chk("shadow_stall", int'(stall), 0); adv();
    nop();
    sample(); chk("shadow_sErs", int'(s_E_rs), 2); adv();

    // Writes to $0 are never hazards.
    set_d(0, 3, 0, 3, 0, 1, 3, 0, 0, 0);
    sample(); adv();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); chk("r0_stall", int'(stall), 0); chk("r0_sDrs", int'(s_D_rs), 0); adv();

    // div then mflo: stalled for exactly 11 cycles.
    nop();
    for (int i = 0; i < 4; i++) begin sample(); adv(); end
    set_d(0, 3, 0, 3, 0, 0, 0, 1, 1, 1);
    sample(); chk("div_issue_stall", int'(stall), 0); adv();
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (!stall) break;
      cnt++;
      adv();
    end
    chk("div_stall_cycles", cnt, 11);
    adv();

    // Reset in the middle of a divide aborts the count.
    nop();
    for (int i = 0; i < 4; i++) begin sample(); adv(); end
    set_d(0, 3, 0, 3, 0, 0, 0, 1, 1, 1);
    sample(); adv();
    nop();
    for (int i = 0; i < 5; i++) begin sample(); adv(); end
    chk("mid_div_left", md_left, 6);
    reset = 1'b1;
    set_d(1, 0, 2, 0, 1, 1, 2, 0, 0, 1);
    adv();
    reset = 1'b0;
    sample();
    chk("abort_busy",  int'(md_busy), 0);
    chk("abort_stall", int'(stall), 0);
    chk("abort_sErs",  int'(s_E_rs), 0);
    adv();

    // Random traffic; a stalled D instruction is re-presented unchanged.
    for (int i = 0; i < 3000; i++) begin
      sample();
      @(posedge clk);
      model_update();
      #1;
      reset = ($urandom_range(199) == 0);
      if (!last_stall || reset) rand_d();
    end
    reset = 1'b0;
    sample();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
